fetch_pc_gen: RTL

Fetch-stage next-PC generator that sits directly upstream of the branch predictor. It drives the fetch PC to instruction memory and to the predictor lookup port. It selects the next PC from the execute-stage redirect, the predictor's taken target, or sequential PC+4. Each issued fetch's prediction is queued in an in-flight FIFO so execute can pop it and compare it with the resolved branch outcome.

---
 rtl/fetch_pc_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator with an in-flight prediction FIFO for execute.
// Define PC_GEN_STATS_EN to add saturating redirect / predicted-taken counters.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_stall_en,
  input  logic        e_redirect_en,
  input  logic [31:0] e_redirect_pc,
  input  logic        e_pop_en,
  input  logic        bp_out_f_predicted_en,
  input  logic        bp_out_f_predicted_taken_en,
  input  logic [31:0] bp_out_f_predicted_pc,
  output logic [31:0] pc_out_f_pc,
  output logic        pc_out_f_valid,
  output logic        pc_out_e_pred_valid,
  output logic        pc_out_e_pred_taken_en,
  output logic [31:0] pc_out_e_pred_pc,
  output logic        pc_out_fifo_full
`ifdef PC_GEN_STATS_EN
  ,
  output logic [15:0] pc_out_stat_redirects,
  output logic [15:0] pc_out_stat_pred_taken
`endif
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_BUBBLE = 2'd2
  } state_e;

  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ZERO = (FIFO_AW+1)'(0);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ZERO = FIFO_AW'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  state_e               state_q;
  logic [31:0]          pc_q, pc_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic [31:0]          fifo_pc_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_taken_q;

  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        pred_taken_s;
  logic        fetch_go_s;
  logic        pop_s;
  logic [31:0] next_pc_s;

  assign fifo_empty_s = (count_q == CNT_ZERO);
  assign fifo_full_s  = (count_q == CNT_FULL);
  assign pred_taken_s = bp_out_f_predicted_en && bp_out_f_predicted_taken_en;
  // A full FIFO blocks issue even if a pop frees a slot this cycle.
  assign fetch_go_s   = (state_q == S_FETCH) && !f_stall_en && !fifo_full_s && !e_redirect_en;
  assign pop_s        = e_pop_en && !fifo_empty_s && !e_redirect_en;
  assign next_pc_s    = pred_taken_s ? (bp_out_f_predicted_pc & 32'hFFFF_FFFC)
                                     : (pc_q + 32'd4);

  // Next PC, FIFO pointers and occupancy; redirect flushes and overrides all.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (e_redirect_en) begin
      pc_d     = e_redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (fetch_go_s) begin
        pc_d     = next_pc_s;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({fetch_go_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch sequencing FSM plus PC and FIFO bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      rd_ptr_q <= PTR_ZERO;
      wr_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (e_redirect_en) begin
        state_q <= S_BUBBLE;
      end else begin
        case (state_q)
          S_BOOT:   state_q <= S_FETCH;
          S_FETCH:  state_q <= S_FETCH;
          S_BUBBLE: state_q <= S_FETCH;
          default:  state_q <= S_BOOT;
        endcase
      end
    end
  end

  // Prediction storage, written at wr_ptr on every issued fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i] <= 32'd0;
      end
      fifo_taken_q <= {FIFO_DEPTH{1'b0}};
    end else if (fetch_go_s) begin
      fifo_pc_q[wr_ptr_q]    <= next_pc_s;
      fifo_taken_q[wr_ptr_q] <= pred_taken_s;
    end
  end

  assign pc_out_f_pc            = pc_q;
  assign pc_out_f_valid         = fetch_go_s;
  assign pc_out_e_pred_valid    = !fifo_empty_s;
  assign pc_out_e_pred_taken_en = fifo_empty_s ? 1'b0 : fifo_taken_q[rd_ptr_q];
  assign pc_out_e_pred_pc       = fifo_empty_s ? 32'd0 : fifo_pc_q[rd_ptr_q];
  assign pc_out_fifo_full       = fifo_full_s;

`ifdef PC_GEN_STATS_EN
  logic [15:0] stat_redirects_q;
  logic [15:0] stat_pred_taken_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_redirects_q  <= 16'd0;
      stat_pred_taken_q <= 16'd0;
    end else begin
      if (e_redirect_en && (stat_redirects_q != 16'hFFFF)) begin
        stat_redirects_q <= stat_redirects_q + 16'd1;
      end
      if (fetch_go_s && pred_taken_s && (stat_pred_taken_q != 16'hFFFF)) begin
        stat_pred_taken_q <= stat_pred_taken_q + 16'd1;
      end
    end
  end

  assign pc_out_stat_redirects  = stat_redirects_q;
  assign pc_out_stat_pred_taken = stat_pred_taken_q;
`endif

endmodule
